caravel_la_counter: RTL and testbench



---
 rtl/caravel_la_counter_pkg.sv | 29 ++
 rtl/caravel_la_counter_core.sv | 56 +++++
 rtl/caravel_la_counter.sv | 131 +++++++++++++
 tb/tb_caravel_la_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_la_counter_pkg.sv
// caravel_la_counter_pkg
// Shared constants for the Caravel user-area LA counter: default counter
// width, logic-analyzer lane assignments, bus widths, and a helper that
// expands Wishbone byte enables into a bit mask.
package caravel_la_counter_pkg;

  localparam int BITS_DEFAULT = 32;
  localparam int WB_WIDTH     = 32;
  localparam int LA_WIDTH     = 128;
  localparam int IO_WIDTH     = 38;
  localparam int IRQ_WIDTH    = 3;

  // LA lanes: 63..32 override value/mask, 64 count clock/enable, 65 reset
  localparam int LA_OVR_LO  = 32;
  localparam int LA_OVR_HI  = 63;
  localparam int LA_EN_BIT  = 64;
  localparam int LA_RST_BIT = 65;

  // Expand 4 byte enables into a 32-bit write mask
  function automatic logic [WB_WIDTH-1:0] sel_to_mask(input logic [3:0] sel);
    logic [WB_WIDTH-1:0] mask;
    mask = {WB_WIDTH{1'b0}};
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/caravel_la_counter_core.sv
// caravel_la_counter_core
// Count register with byte-masked bus write, bit-masked LA override,
// enable-gated increment and natural wrap modulo 2^BITS.
// Ports:
//   clock     - system clock
//   rst       - synchronous active-high reset (highest priority)
//   wr_en     - bus write this cycle (beats override and increment)
//   wr_mask   - per-bit mask of bus-written bits
//   wr_data   - bus write data
//   ovr_mask  - per-bit LA override mask (any bit set suppresses increment)
//   ovr_data  - LA override data
//   en        - increment enable
//   count     - registered count value
module caravel_la_counter_core
  import caravel_la_counter_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_mask,
  input  logic [BITS-1:0] wr_data,
  input  logic [BITS-1:0] ovr_mask,
  input  logic [BITS-1:0] ovr_data,
  input  logic            en,
  output logic [BITS-1:0] count
);

  logic [BITS-1:0] count_r;
  logic [BITS-1:0] count_nxt_s;

  // Next-count selection in priority order: reset, bus write, override, increment
  always_comb begin
    count_nxt_s = count_r;
    if (rst) begin
      count_nxt_s = {BITS{1'b0}};
    end else if (wr_en) begin
      count_nxt_s = (count_r & ~wr_mask) | (wr_data & wr_mask);
    end else if (|ovr_mask) begin
      count_nxt_s = (count_r & ~ovr_mask) | (ovr_data & ovr_mask);
    end else if (en) begin
      count_nxt_s = count_r + BITS'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register (reset folded into next-state logic)
  always_ff @(posedge clock) begin
    count_r <= count_nxt_s;
  end

  assign count = count_r;

endmodule

// File: rtl/caravel_la_counter.sv
// caravel_la_counter
// User-area counter for the Caravel SoC. The management core loads the
// counter over Wishbone and can override, gate or reset it through the
// logic-analyzer lanes. The count is driven to the pads and to la_data_out.
// Ports:
//   wb_clk_i, wb_rst_i   - clock, synchronous active-high reset
//   wbs_*                - Wishbone slave (address ignored)
//   la_data_in/out, la_oenb - 128-bit LA interface (oenb active-low)
//   io_in/io_out/io_oeb  - 38 user pads (oeb active-low)
//   irq                  - interrupts, tied low
module caravel_la_counter
  import caravel_la_counter_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [WB_WIDTH-1:0]  wbs_adr_i,
  input  logic [WB_WIDTH-1:0]  wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [WB_WIDTH-1:0]  wbs_dat_o,
  input  logic [LA_WIDTH-1:0]  la_data_in,
  output logic [LA_WIDTH-1:0]  la_data_out,
  input  logic [LA_WIDTH-1:0]  la_oenb,
  input  logic [IO_WIDTH-1:0]  io_in,
  output logic [IO_WIDTH-1:0]  io_out,
  output logic [IO_WIDTH-1:0]  io_oeb,
  output logic [IRQ_WIDTH-1:0] irq
);

  logic                rst_s;
  logic                valid_s;
  logic                wb_take_s;
  logic                wr_en_s;
  logic [WB_WIDTH-1:0] sel_mask_s;
  logic [WB_WIDTH-1:0] la_write_s;
  logic                en_s;
  logic                la_edge_r;
  logic                ack_r;
  logic [WB_WIDTH-1:0] dat_r;
  logic [BITS-1:0]     count_s;
  logic [WB_WIDTH-1:0] count_ext_s;
  logic [LA_WIDTH-1:0] la_out_s;
  logic [IO_WIDTH-1:0] io_out_s;
  logic                unused_s;

  // LA lane 65 can reset the block when the management core drives it
  assign rst_s = wb_rst_i | (~la_oenb[LA_RST_BIT] & la_data_in[LA_RST_BIT]);

  assign valid_s    = wbs_cyc_i & wbs_stb_i;
  // A transfer is taken only when no ack is pending, so ack pulses one cycle
  assign wb_take_s  = valid_s & ~ack_r;
  assign wr_en_s    = wb_take_s & wbs_we_i;
  assign sel_mask_s = sel_to_mask(wbs_sel_i);
  assign la_write_s = ~la_oenb[LA_OVR_HI:LA_OVR_LO];

  // Free run unless LA drives lane 64; then count once per rising edge of it
  always_comb begin
    en_s = 1'b1;
    if (la_oenb[LA_EN_BIT]) begin
      en_s = 1'b1;
    end else begin
      en_s = la_data_in[LA_EN_BIT] & ~la_edge_r;
    end
  end

  // Previous value of LA lane 64 for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      la_edge_r <= 1'b0;
    end else begin
      la_edge_r <= la_data_in[LA_EN_BIT];
    end
  end

  // Wishbone ack pulse and read-data capture
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      ack_r <= 1'b0;
      dat_r <= {WB_WIDTH{1'b0}};
    end else begin
      ack_r <= wb_take_s;
      if (wb_take_s) begin
        dat_r <= count_ext_s;
      end else begin
        dat_r <= dat_r;
      end
    end
  end

  caravel_la_counter_core #(
    .BITS (BITS)
  ) u_core (
    .clock    (wb_clk_i),
    .rst      (rst_s),
    .wr_en    (wr_en_s),
    .wr_mask  (sel_mask_s[BITS-1:0]),
    .wr_data  (wbs_dat_i[BITS-1:0]),
    .ovr_mask (la_write_s[BITS-1:0]),
    .ovr_data (la_data_in[LA_OVR_LO +: BITS]),
    .en       (en_s),
    .count    (count_s)
  );

  // Zero-extend the count onto the bus, LA and pad views
  always_comb begin
    count_ext_s = {WB_WIDTH{1'b0}};
    la_out_s    = {LA_WIDTH{1'b0}};
    io_out_s    = {IO_WIDTH{1'b0}};
    count_ext_s[BITS-1:0] = count_s;
    la_out_s[BITS-1:0]    = count_s;
    io_out_s[BITS-1:0]    = count_s;
  end

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign la_data_out = la_out_s;
  assign io_out      = io_out_s;
  assign io_oeb      = {IO_WIDTH{rst_s}};
  assign irq         = {IRQ_WIDTH{1'b0}};

  // Inputs that carry no function in this block
  assign unused_s = ^{io_in, wbs_adr_i, la_data_in[LA_WIDTH-1:LA_RST_BIT+1],
                      la_data_in[LA_OVR_LO-1:0], la_oenb[LA_WIDTH-1:LA_RST_BIT+1],
                      la_oenb[LA_OVR_LO-1:0]};

endmodule

// File: tb/tb_caravel_la_counter.sv
// Directed testbench for caravel_la_counter: linear stimulus, immediate
// assertions against hand-computed expected values.
module tb_caravel_la_counter;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic         wbs_cyc_i;
  logic         wbs_stb_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i;
  logic [31:0]  wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in;
  logic [127:0] la_data_out;
  logic [127:0] la_oenb;
  logic [37:0]  io_in;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;
  logic [2:0]   irq;

  int tests_run;
  int tests_failed;

  caravel_la_counter dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .la_data_in  (la_data_in),
    .la_data_out (la_data_out),
    .la_oenb     (la_oenb),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_start(input logic we, input logic [3:0] sel, input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'b0000;
    wbs_dat_i = 32'h0000_0000;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wb_rst_i   = 1'b1;
    wbs_adr_i  = 32'h3000_0000;
    la_data_in = 128'd0;
    la_oenb    = {128{1'b1}};
    io_in      = 38'd0;
    wb_idle();

    // Reset held two cycles
    tick();
    tick();
    check("rst_count", la_data_out, 128'd0);
    check("rst_oeb", {90'd0, io_oeb}, {90'd0, {38{1'b1}}});
    check("rst_ack", {127'd0, wbs_ack_o}, 128'd0);
    check("rst_dat", {96'd0, wbs_dat_o}, 128'd0);
    check("irq", {125'd0, irq}, 128'd0);

    // Release: pads enabled, free run 1,2,3
    wb_rst_i = 1'b0;
    #1;
    check("oeb_run", {90'd0, io_oeb}, 128'd0);
    tick(); check("run1", la_data_out, 128'd1);
    tick(); check("run2", la_data_out, 128'd2);
    tick(); check("run3", la_data_out, 128'd3);

    // Full Wishbone write, one-cycle ack
    wb_start(1'b1, 4'b1111, 32'h0000_AB40);
    tick();
    check("wr_ack", {127'd0, wbs_ack_o}, 128'd1);
    check("wr_count", la_data_out, 128'h0000_AB40);
    wb_idle();
    tick();
    check("wr_ack_drop", {127'd0, wbs_ack_o}, 128'd0);
    check("wr_inc", la_data_out, 128'h0000_AB41);
    check("io_out", {90'd0, io_out}, 128'h0000_AB41);

    // Freeze counting (LA lane 64 driven low) for byte-write test
    la_oenb[64] = 1'b0;
    wb_start(1'b1, 4'b1111, 32'h1234_5678);
    tick();
    wb_idle();
    tick();
    check("freeze", la_data_out, 128'h1234_5678);
    wb_start(1'b1, 4'b0010, 32'hAABB_CCDD);
    tick();
    check("byte_wr", la_data_out, 128'h1234_CC78);
    wb_idle();
    tick();
    wb_start(1'b0, 4'b1111, 32'h0000_0000);
    tick();
    check("rd_ack", {127'd0, wbs_ack_o}, 128'd1);
    check("rd_dat", {96'd0, wbs_dat_o}, 128'h1234_CC78);
    wb_idle();
    tick();
    check("rd_hold", {96'd0, wbs_dat_o}, 128'h1234_CC78);
    check("rd_count", la_data_out, 128'h1234_CC78);

    // Full LA override, with free run re-enabled
    la_oenb[64] = 1'b1;
    la_oenb[63:32] = 32'h0000_0000;
    la_data_in[63:32] = 32'hAB51_0000;
    tick(); check("ovr1", la_data_out, 128'hAB51_0000);
    tick(); check("ovr2", la_data_out, 128'hAB51_0000);
    la_oenb[63:32] = 32'hFFFF_FFFF;
    tick(); check("ovr_rel", la_data_out, 128'hAB51_0001);
    // Override only bit 0
    la_oenb[63:32] = 32'hFFFF_FFFE;
    la_data_in[63:32] = 32'h0000_0000;
    tick(); check("ovr_b0_lo", la_data_out, 128'hAB51_0000);
    la_data_in[63:32] = 32'hFFFF_FFFF;
    tick(); check("ovr_b0_hi", la_data_out, 128'hAB51_0001);
    la_oenb[63:32] = 32'hFFFF_FFFF;
    la_data_in[63:32] = 32'h0000_0000;

    // LA-gated counting: exactly one step per rising edge of lane 64
    la_oenb[64] = 1'b0;
    la_data_in[64] = 1'b0;
    wb_start(1'b1, 4'b1111, 32'h0000_0100);
    tick();
    wb_idle();
    tick();
    check("gate_load", la_data_out, 128'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      la_data_in[64] = 1'b1;
      tick();
      tick();
      la_data_in[64] = 1'b0;
      tick();
    end
    tick();
    check("gate_3", la_data_out, 128'h0000_0103);

    // LA-driven reset
    la_oenb[65] = 1'b0;
    la_data_in[65] = 1'b1;
    #1;
    check("la_rst_oeb", {90'd0, io_oeb}, {90'd0, {38{1'b1}}});
    tick();
    check("la_rst", la_data_out, 128'd0);
    la_data_in[65] = 1'b0;
    la_oenb[65] = 1'b1;
    la_oenb[64] = 1'b1;

    // Wrap
    wb_start(1'b1, 4'b1111, 32'hFFFF_FFFF);
    tick();
    check("wrap_load", la_data_out, 128'hFFFF_FFFF);
    wb_idle();
    tick();
    check("wrap", la_data_out, 128'd0);

    // Wishbone beats simultaneous LA override; override applies next cycle
    wb_start(1'b1, 4'b1111, 32'h0000_0005);
    la_oenb[63:32] = 32'h0000_0000;
    la_data_in[63:32] = 32'h0000_0009;
    tick();
    check("prio_wb", la_data_out, 128'h5);
    wb_idle();
    tick();
    check("prio_la", la_data_out, 128'h9);
    la_oenb[63:32] = 32'hFFFF_FFFF;
    la_data_in[63:32] = 32'h0000_0000;

    // Reset during a transfer: no ack, no write
    tick();
    wb_start(1'b1, 4'b1111, 32'h0000_0077);
    wb_rst_i = 1'b1;
    tick();
    check("rst_mid_ack", {127'd0, wbs_ack_o}, 128'd0);
    check("rst_mid_cnt", la_data_out, 128'd0);
    wb_rst_i = 1'b0;
    wb_idle();
    tick();
    check("post_rst", la_data_out, 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
